// File: rtl/fdtd_step_ctrl.sv
// FDTD timestep sequencer: loads old Hy/Ez into the field buffer, issues the Hy then Ez
// update passes, and drains the new fields back to data memory.
//
// state    | meaning
// IDLE     | waiting for start_i
// LOAD_HY  | loader delivering previous Hy words into the buffer
// LOAD_EZ  | loader delivering previous Ez words into the buffer
// CALC_HY  | issuing Hy update reads, collecting Hy writes from the pipeline
// CALC_EZ  | issuing Ez update reads, collecting Ez writes from the pipeline
// DRAIN_HY | data memory accepting new Hy words
// DRAIN_EZ | data memory accepting new Ez words
module fdtd_step_ctrl #(
  parameter int FDTD_DATA_WIDTH   = 32,
  parameter int BUFFER_ADDR_WIDTH = 6,
  parameter int FDTD_BUFFER_DEPTH = 64,
  parameter int CALC_LATENCY      = 4
) (
  input  logic                         CLK,
  input  logic                         RST_N,
  input  logic                         start_i,
  input  logic [BUFFER_ADDR_WIDTH:0]   size_i,
  output logic                         busy_o,
  output logic                         done_o,
  output logic                         ld_req_o,
  output logic                         ld_sel_o,
  input  logic                         ld_valid_i,
  output logic                         buffer_Hy_start_o,
  output logic                         buffer_Ez_start_o,
  output logic                         buffer_Hy_end_o,
  output logic                         buffer_Ez_end_o,
  output logic                         rd_Hy_old_en_o,
  output logic                         rd_Ez_old_en_o,
  output logic [BUFFER_ADDR_WIDTH-1:0] rd_old_addr_o,
  output logic                         calc_sel_o,
  output logic                         wrt_Hy_n_en_o,
  output logic                         wrt_Ez_n_en_o,
  output logic [BUFFER_ADDR_WIDTH-1:0] wrt_n_addr_o,
  output logic                         mem_rd_Hy_en_o,
  output logic                         mem_rd_Ez_en_o,
  output logic                         mem_rd_end_o,
  input  logic                         wrtvalid_sgl_i
);

  localparam int AW = BUFFER_ADDR_WIDTH;
  localparam int CL = CALC_LATENCY;
  localparam logic [AW:0] DEPTH_N = (AW+1)'(FDTD_BUFFER_DEPTH);
  localparam logic [AW:0] ONE     = (AW+1)'(1);

  if (FDTD_DATA_WIDTH < 1 || CALC_LATENCY < 1 ||
      FDTD_BUFFER_DEPTH != (1 << BUFFER_ADDR_WIDTH)) begin : g_bad_params
    $error("fdtd_step_ctrl: inconsistent parameters");
  end

  typedef enum logic [2:0] {
    IDLE, LOAD_HY, LOAD_EZ, CALC_HY, CALC_EZ, DRAIN_HY, DRAIN_EZ
  } state_t;

  state_t        state, state_nxt;
  logic [AW:0]   n_q, n_nxt;
  logic [AW:0]   remain, remain_nxt;
  logic [AW:0]   iss_cnt, iss_nxt;
  logic          act_q, act_nxt;
  logic          in_load, in_drain, pipe_busy;
  logic          busy_nxt, done_nxt, ld_sel_nxt, calc_sel_nxt;
  logic          hy_start_nxt, ez_start_nxt, hy_end_nxt, ez_end_nxt;
  logic          rd_en_nxt;
  logic [AW-1:0] rd_addr_nxt;
  logic          mem_hy_nxt, mem_ez_nxt, mem_end_nxt;

  logic [CL:0]   wv_hy, wv_ez;
  logic [AW-1:0] pipe_addr [CL+1];

  assign in_load   = (state == LOAD_HY) || (state == LOAD_EZ);
  assign in_drain  = (state == DRAIN_HY) || (state == DRAIN_EZ);
  assign pipe_busy = (|wv_hy[CL-1:0]) || (|wv_ez[CL-1:0]);

  // The only unregistered output: request falls in the same cycle as the last word.
  assign ld_req_o = act_q && in_load && !(ld_valid_i && (remain == ONE));

  always_comb begin
    state_nxt    = state;
    n_nxt        = n_q;
    remain_nxt   = remain;
    iss_nxt      = iss_cnt;
    done_nxt     = 1'b0;
    hy_start_nxt = 1'b0;
    ez_start_nxt = 1'b0;
    hy_end_nxt   = 1'b0;
    ez_end_nxt   = 1'b0;
    rd_en_nxt    = 1'b0;
    rd_addr_nxt  = rd_old_addr_o;
    mem_hy_nxt   = 1'b0;
    mem_ez_nxt   = 1'b0;
    mem_end_nxt  = 1'b0;

    case (state)
      IDLE: begin
        if (start_i) begin
          if (size_i == '0) begin
            done_nxt = 1'b1;
          end else begin
            n_nxt        = (size_i > DEPTH_N) ? DEPTH_N : size_i;
            remain_nxt   = (size_i > DEPTH_N) ? DEPTH_N : size_i;
            hy_start_nxt = 1'b1;
            state_nxt    = LOAD_HY;
          end
        end
      end
      LOAD_HY: begin
        if (act_q && ld_valid_i) begin
          remain_nxt = remain - ONE;
          if (remain == ONE) begin
            remain_nxt   = n_q;
            hy_end_nxt   = 1'b1;
            ez_start_nxt = 1'b1;
            state_nxt    = LOAD_EZ;
          end
        end
      end
      LOAD_EZ: begin
        if (act_q && ld_valid_i) begin
          remain_nxt = remain - ONE;
          if (remain == ONE) begin
            ez_end_nxt  = 1'b1;
            rd_en_nxt   = 1'b1;
            rd_addr_nxt = '0;
            iss_nxt     = ONE;
            state_nxt   = CALC_HY;
          end
        end
      end
      CALC_HY, CALC_EZ: begin
        if (iss_cnt < n_q) begin
          rd_en_nxt   = 1'b1;
          rd_addr_nxt = iss_cnt[AW-1:0];
          iss_nxt     = iss_cnt + ONE;
        end else if (!rd_Hy_old_en_o && !pipe_busy) begin
          // The last write is on the outputs this cycle; nothing left behind it.
          if (state == CALC_HY) begin
            rd_en_nxt   = 1'b1;
            rd_addr_nxt = '0;
            iss_nxt     = ONE;
            state_nxt   = CALC_EZ;
          end else begin
            remain_nxt  = n_q;
            mem_hy_nxt  = 1'b1;
            state_nxt   = DRAIN_HY;
          end
        end
      end
      DRAIN_HY: begin
        if (act_q && wrtvalid_sgl_i) begin
          remain_nxt = remain - ONE;
          if (remain == ONE) begin
            remain_nxt  = n_q;
            mem_end_nxt = 1'b1;
            mem_ez_nxt  = 1'b1;
            state_nxt   = DRAIN_EZ;
          end
        end
      end
      DRAIN_EZ: begin
        if (act_q && wrtvalid_sgl_i) begin
          remain_nxt = remain - ONE;
          if (remain == ONE) begin
            mem_end_nxt = 1'b1;
            done_nxt    = 1'b1;
            state_nxt   = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    act_nxt      = (in_load || in_drain) && (state_nxt == state);
    busy_nxt     = (state_nxt != IDLE);
    ld_sel_nxt   = (state_nxt == LOAD_EZ);
    calc_sel_nxt = (state_nxt == CALC_EZ);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state             <= IDLE;
      n_q               <= '0;
      remain            <= '0;
      iss_cnt           <= '0;
      act_q             <= 1'b0;
      busy_o            <= 1'b0;
      done_o            <= 1'b0;
      ld_sel_o          <= 1'b0;
      buffer_Hy_start_o <= 1'b0;
      buffer_Ez_start_o <= 1'b0;
      buffer_Hy_end_o   <= 1'b0;
      buffer_Ez_end_o   <= 1'b0;
      rd_Hy_old_en_o    <= 1'b0;
      rd_Ez_old_en_o    <= 1'b0;
      rd_old_addr_o     <= '0;
      calc_sel_o        <= 1'b0;
      mem_rd_Hy_en_o    <= 1'b0;
      mem_rd_Ez_en_o    <= 1'b0;
      mem_rd_end_o      <= 1'b0;
    end else begin
      state             <= state_nxt;
      n_q               <= n_nxt;
      remain            <= remain_nxt;
      iss_cnt           <= iss_nxt;
      act_q             <= act_nxt;
      busy_o            <= busy_nxt;
      done_o            <= done_nxt;
      ld_sel_o          <= ld_sel_nxt;
      buffer_Hy_start_o <= hy_start_nxt;
      buffer_Ez_start_o <= ez_start_nxt;
      buffer_Hy_end_o   <= hy_end_nxt;
      buffer_Ez_end_o   <= ez_end_nxt;
      rd_Hy_old_en_o    <= rd_en_nxt;
      rd_Ez_old_en_o    <= rd_en_nxt;
      rd_old_addr_o     <= rd_addr_nxt;
      calc_sel_o        <= calc_sel_nxt;
      mem_rd_Hy_en_o    <= mem_hy_nxt;
      mem_rd_Ez_en_o    <= mem_ez_nxt;
      mem_rd_end_o      <= mem_end_nxt;
    end
  end

  // Issue tracker: valid and address ride CL+1 stages to become the write strobe.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wv_hy <= '0;
      wv_ez <= '0;
      for (int i = 0; i <= CL; i++) pipe_addr[i] <= '0;
    end else begin
      wv_hy <= {wv_hy[CL-1:0], rd_Hy_old_en_o && !calc_sel_o};
      wv_ez <= {wv_ez[CL-1:0], rd_Hy_old_en_o && calc_sel_o};
      pipe_addr[0] <= rd_old_addr_o;
      for (int i = 1; i <= CL; i++) pipe_addr[i] <= pipe_addr[i-1];
    end
  end

  assign wrt_Hy_n_en_o = wv_hy[CL];
  assign wrt_Ez_n_en_o = wv_ez[CL];
  assign wrt_n_addr_o  = pipe_addr[CL];

endmodule

// File: doc/fdtd_step_ctrl.md
# fdtd_step_ctrl

Sequencer for one FDTD timestep over the field buffer: loads Hy/Ez of the previous timestep from data memory into the buffer, issues the Hy then Ez update passes to the arithmetic pipeline, and drains the new Hy/Ez values back to data memory. It sits between the FDTD register interface (start/size/done) and the field buffer, driving all buffer start/end strobes, read/write addresses and enables.

## Interface
- FDTD_DATA_WIDTH, 32, data word width (pass-through only)
- BUFFER_ADDR_WIDTH, 6, buffer address width
- FDTD_BUFFER_DEPTH, 64, buffer words; must equal 2**BUFFER_ADDR_WIDTH
- CALC_LATENCY, 4, cycles from buffer read data valid to update result valid (>=1)

Ports:
- CLK  in  1  clock
- RST_N  in  1  reset; asynchronous, active-low
- start_i  in  1  timestep start pulse; honoured only in IDLE
- size_i  in  BUFFER_ADDR_WIDTH+1  cell count N, sampled on accepted start
- busy_o  out  1  high in every state except IDLE
- done_o  out  1  one-cycle pulse at end of DRAIN_EZ (or size 0)
- ld_req_o  out  1  level; loader may deliver words
- ld_sel_o  out  1  0 = Hy, 1 = Ez, valid while ld_req_o
- ld_valid_i  in  1  loader word valid (also wired to buffer wrtvalid)
- buffer_Hy_start_o / buffer_Ez_start_o  out  1  one-cycle load-start pulses
- buffer_Hy_end_o / buffer_Ez_end_o  out  1  one-cycle load-end pulses
- rd_Hy_old_en_o, rd_Ez_old_en_o  out  1  old-field read enables
- rd_old_addr_o  out  BUFFER_ADDR_WIDTH  read address for both old RAMs
- calc_sel_o  out  1  0 = Hy pass, 1 = Ez pass
- wrt_Hy_n_en_o, wrt_Ez_n_en_o  out  1  new-field write enables
- wrt_n_addr_o  out  BUFFER_ADDR_WIDTH  write address for both new RAMs
- mem_rd_Hy_en_o, mem_rd_Ez_en_o  out  1  one-cycle drain-start pulses
- mem_rd_end_o  out  1  one-cycle drain-end pulse
- wrtvalid_sgl_i  in  1  data memory accepted one drained word

## Operation
- States: IDLE -> LOAD_HY -> LOAD_EZ -> CALC_HY -> CALC_EZ -> DRAIN_HY -> DRAIN_EZ -> IDLE.
- IDLE: start_i latches N = min(size_i, FDTD_BUFFER_DEPTH). N == 0: done_o pulses next cycle, no other strobe, stay IDLE.
- LOAD_x: entry cycle pulses buffer_x_start_o; ld_req_o high from second cycle; one counter counts ld_valid_i; on the N-th valid, ld_req_o drops same cycle (combinational), buffer_x_end_o pulses next cycle with state advance. ld_valid_i outside ld_req_o is ignored.
- CALC_x: issue counter i = 0..N-1, one per cycle: rd_x enables high (both Hy and Ez old enables in both passes), rd_old_addr_o = i. Issue address travels a (CALC_LATENCY+1)-deep valid/address shift register; its output drives wrt_x_n_en_o / wrt_n_addr_o. Advance when issue done and pipeline empty (exactly N writes per pass, addresses 0..N-1 in order).
- DRAIN_x: entry pulses mem_rd_x_en_o; counter counts wrtvalid_sgl_i; on N-th, mem_rd_end_o pulses next cycle with state advance. DRAIN_EZ exit pulses done_o together with mem_rd_end_o.
- start_i while busy: ignored, no queueing. size_i changes while busy: no effect.
- Counters BUFFER_ADDR_WIDTH+1 bits; N = 64 terminates at count 64, never wraps.

## Timing
- All outputs registered except ld_req_o drop; all outputs 0 during and after reset.
- Reset mid-operation: immediate return to IDLE, pipeline flushed, no further writes.
- CALC pass duration: N + CALC_LATENCY + 1 cycles after entry; first write CALC_LATENCY+1 cycles after first issue.
- Back-to-back: done_o cycle is IDLE; start_i in the following cycle is accepted.

## Test plan
- N = 4, loader valid every cycle, sgl every cycle -> 4 Hy loads, 4 Ez loads, writes at addr 0..3 each pass 5 cycles after issue, done_o exactly once.
- N = 64, random gaps on ld_valid_i and wrtvalid_sgl_i -> exactly 64 counted each phase, addr 63 last, no wrap to 0.
- size_i = 0 -> done_o next cycle, busy_o never high, no strobes; size_i = 100 -> behaves as 64.
- start_i pulsed during CALC_HY and DRAIN_EZ -> ignored; second start the cycle after done_o -> new timestep begins.
- RST_N low during CALC_EZ with writes in flight -> all outputs 0 at once, no wrt_*_en after release, next start runs a clean timestep.
